// File: rtl/cnt_timer_pkg.sv
// Shared types and constants for the counter-based timer controller.
// State encoding, mode values and configuration reset defaults.
package cnt_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int unsigned DEF_PRESCALE = 0;
  localparam logic        DEF_MODE     = MODE_ONESHOT;

endpackage

// File: rtl/cnt_timer_ctrl_prescaler.sv
// Clock divider for the timer: tick once every prescale+1 enabled cycles.
// Tick is combinational so the counter reacts in the same cycle.
module cnt_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q;

  assign tick = enable && (cnt_q == prescale);

  // Divider count: restart on clear, wrap on tick, hold when disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_timer_ctrl.sv
// Programmable timer: prescaled up-counter with start/stop sequencing,
// one-shot/periodic modes and a sticky interrupt with overrun flag.
module cnt_timer_ctrl
  import cnt_timer_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] cnt,
  output logic             cout,
  output logic             busy,
  output logic             irq,
  output logic             overrun,
  output logic             cfg_err
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  logic [PRE_W-1:0] prescale_q;
  logic             mode_q;
  logic             cout_q;
  logic             irq_q;
  logic             ovr_q;
  logic             err_q;

  logic run;
  logic go;
  logic tick;
  logic term;

  assign run  = (state_q == ST_RUN);
  assign go   = !run && start && !stop;
  assign term = tick && (cnt_q == period_q);

  // Prescaler is frozen on the stop cycle so nothing is counted then.
  cnt_prescaler #(
    .PRE_W (PRE_W)
  ) u_pre (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (go),
    .enable   (run && !stop),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // Control FSM, counter, config registers and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      period_q   <= '1;
      prescale_q <= PRE_W'(DEF_PRESCALE);
      mode_q     <= DEF_MODE;
      cout_q     <= 1'b0;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cout_q <= 1'b0;
      err_q  <= 1'b0;
      if (irq_ack) begin
        irq_q <= 1'b0;
        ovr_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_we) begin
            period_q   <= cfg_period;
            prescale_q <= cfg_prescale;
            mode_q     <= cfg_mode;
          end
          if (go) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          if (cfg_we) begin
            err_q <= 1'b1;
          end
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (term) begin
            cout_q <= 1'b1;
            irq_q  <= 1'b1;
            if (irq_q && !irq_ack) begin
              ovr_q <= 1'b1;
            end
            if (mode_q == MODE_PERIODIC) begin
              cnt_q <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (tick) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cnt     = cnt_q;
  assign cout    = cout_q;
  assign busy    = run;
  assign irq     = irq_q;
  assign overrun = ovr_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_cnt_timer_ctrl.sv
// Scoreboard bench for cnt_timer_ctrl: expected cout/cfg_err cycles are
// queued by the stimulus and popped by a negedge monitor.
module tb_cnt_timer_ctrl;

  localparam int CNT_W = 4;
  localparam int PRE_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cfg_we = 1'b0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [PRE_W-1:0] cfg_prescale = '0;
  logic             cfg_mode = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             irq_ack = 1'b0;
  logic [CNT_W-1:0] cnt;
  logic             cout;
  logic             busy;
  logic             irq;
  logic             overrun;
  logic             cfg_err;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int e0;
  int cout_q[$];
  int err_q[$];

  cnt_timer_ctrl #(
    .CNT_W (CNT_W),
    .PRE_W (PRE_W)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_we       (cfg_we),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_mode     (cfg_mode),
    .start        (start),
    .stop         (stop),
    .irq_ack      (irq_ack),
    .cnt          (cnt),
    .cout         (cout),
    .busy         (busy),
    .irq          (irq),
    .overrun      (overrun),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                  name, act, exp, cyc);
  endtask

  // Monitor: every pulse must match the next queued cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (cout) begin
        if (cout_q.size() == 0) chk("cout_unexpected", cyc, -1);
        else chk("cout_cycle", cyc, cout_q.pop_front());
      end
      if (cfg_err) begin
        if (err_q.size() == 0) chk("cfg_err_unexpected", cyc, -1);
        else chk("cfg_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic cfg(int p, int s, bit m);
    cfg_we = 1'b1;
    cfg_period = CNT_W'(p);
    cfg_prescale = PRE_W'(s);
    cfg_mode = m;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_irq", int'(irq), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_err", int'(cfg_err), 0);
    rstn = 1'b1;
    @(negedge clk);

    // periodic, period 3, prescale 1
    cfg(3, 1, 1'b1);
    pulse_start();
    e0 = cyc;
    cout_q.push_back(e0 + 8);
    cout_q.push_back(e0 + 16);
    cout_q.push_back(e0 + 24);
    chk("per_cnt0", int'(cnt), 0);
    chk("per_busy", int'(busy), 1);
    for (int i = 1; i <= 3; i++) begin
      wait_cyc(e0 + 2 * i);
      chk("per_cnt_step", int'(cnt), i);
    end
    wait_cyc(e0 + 8);
    chk("per_wrap", int'(cnt), 0);
    chk("per_irq", int'(irq), 1);
    chk("per_ovr0", int'(overrun), 0);
    wait_cyc(e0 + 25);
    pulse_stop();
    chk("per_stop_busy", int'(busy), 0);
    chk("per_ovr1", int'(overrun), 1);
    chk("per_stop_cnt", int'(cnt), 0);
    ack();
    chk("ack_irq", int'(irq), 0);
    chk("ack_ovr", int'(overrun), 0);

    // one-shot, period 5
    cfg(5, 0, 1'b0);
    pulse_start();
    e0 = cyc;
    cout_q.push_back(e0 + 6);
    wait_cyc(e0 + 5);
    chk("os_cnt5", int'(cnt), 5);
    chk("os_busy1", int'(busy), 1);
    wait_cyc(e0 + 6);
    chk("os_busy0", int'(busy), 0);
    chk("os_hold", int'(cnt), 5);
    chk("os_irq", int'(irq), 1);
    wait_cyc(e0 + 10);
    chk("os_hold_late", int'(cnt), 5);
    pulse_start();
    chk("os_restart_cnt", int'(cnt), 0);
    chk("os_restart_busy", int'(busy), 1);
    @(negedge clk);
    chk("os_restart_step", int'(cnt), 1);
    pulse_stop();
    chk("stop_hold_cnt", int'(cnt), 1);
    chk("stop_busy", int'(busy), 0);
    ack();

    // interrupt handshake, periodic period 1
    cfg(1, 0, 1'b1);
    pulse_start();
    e0 = cyc;
    cout_q.push_back(e0 + 2);
    cout_q.push_back(e0 + 4);
    cout_q.push_back(e0 + 6);
    wait_cyc(e0 + 2);
    chk("hs_irq", int'(irq), 1);
    chk("hs_ovr0", int'(overrun), 0);
    wait_cyc(e0 + 4);
    chk("hs_ovr1", int'(overrun), 1);
    wait_cyc(e0 + 5);
    ack();
    chk("hs_ack_coinc_irq", int'(irq), 1);
    chk("hs_ack_coinc_ovr", int'(overrun), 0);
    pulse_stop();
    chk("hs_stop_busy", int'(busy), 0);
    ack();

    // stop on the terminal-event cycle
    cfg(2, 0, 1'b1);
    pulse_start();
    e0 = cyc;
    wait_cyc(e0 + 2);
    pulse_stop();
    chk("sp_busy", int'(busy), 0);
    chk("sp_cnt", int'(cnt), 2);
    chk("sp_irq", int'(irq), 0);
    wait_cyc(e0 + 6);
    chk("sp_cnt_late", int'(cnt), 2);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("ss_idle", int'(busy), 0);
    @(negedge clk);
    chk("ss_idle2", int'(busy), 0);

    // config write while running
    cfg(2, 0, 1'b0);
    pulse_start();
    e0 = cyc;
    cout_q.push_back(e0 + 3);
    err_q.push_back(e0 + 1);
    cfg(7, 0, 1'b1);
    wait_cyc(e0 + 3);
    chk("cg_busy", int'(busy), 0);
    chk("cg_cnt", int'(cnt), 2);
    ack();

    // period 0: terminal event every cycle
    cfg(0, 0, 1'b1);
    pulse_start();
    e0 = cyc;
    for (int i = 1; i <= 4; i++) cout_q.push_back(e0 + i);
    wait_cyc(e0 + 4);
    chk("p0_cnt", int'(cnt), 0);
    pulse_stop();
    chk("p0_busy", int'(busy), 0);

    // reset mid-run
    pulse_start();
    e0 = cyc;
    cout_q.push_back(e0 + 1);
    cout_q.push_back(e0 + 2);
    wait_cyc(e0 + 2);
    #2 rstn = 1'b0;
    #1;
    chk("mr_cnt", int'(cnt), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_irq", int'(irq), 0);
    chk("mr_ovr", int'(overrun), 0);
    chk("mr_cout", int'(cout), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // reset config: period 15, prescale 0, one-shot
    pulse_start();
    e0 = cyc;
    cout_q.push_back(e0 + 16);
    wait_cyc(e0 + 15);
    chk("def_cnt15", int'(cnt), 15);
    chk("def_busy1", int'(busy), 1);
    wait_cyc(e0 + 16);
    chk("def_busy0", int'(busy), 0);
    chk("def_hold", int'(cnt), 15);
    repeat (2) @(negedge clk);

    chk("cout_q_empty", cout_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cnt_timer_ctrl.md
Name: cnt_timer_ctrl

Overview:
Controller that sequences a CNT_W-bit up-counter (cnt/cout) as a programmable timer for the CPU's timer/interrupt path. It adds configuration registers (period, prescale, mode), start/stop sequencing, and a sticky interrupt with acknowledge handshake. It sits between the CSR/bus write logic and the interrupt controller.

Parameters:
CNT_W, 4, counter width; period range is 0..2^CNT_W-1.
PRE_W, 8, prescaler width; prescale range is 0..2^PRE_W-1.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  asynchronous active-low reset.
cfg_we  in  1  configuration write strobe.
cfg_period  in  CNT_W  terminal count value.
cfg_prescale  in  PRE_W  one counter tick every cfg_prescale+1 cycles.
cfg_mode  in  1  0 = one-shot, 1 = periodic.
start  in  1  one-cycle start request.
stop  in  1  one-cycle stop request.
irq_ack  in  1  clears irq and overrun.
cnt  out  CNT_W  current count.
cout  out  1  one-cycle terminal-count pulse, registered.
busy  out  1  high in RUN.
irq  out  1  sticky terminal-count interrupt.
overrun  out  1  sticky; a terminal event occurred while irq was already set.
cfg_err  out  1  one-cycle pulse: cfg_we while busy, write ignored.

Behaviour:
- Reset (async, rstn=0) values:
  - State IDLE; cnt=0; prescaler count=0; cout=0; busy=0; irq=0; overrun=0; cfg_err=0.
  - Config registers: period=all ones, prescale=0, mode=0.
- States: IDLE and RUN; busy = (state==RUN), registered.
- Configuration:
  - cfg_we in IDLE loads all three config registers at the edge.
  - cfg_we in RUN is ignored and pulses cfg_err for 1 cycle.
- IDLE -> RUN: on start && !stop. At that edge cnt<=0 and prescaler<=0. start in RUN is ignored.
- Prescaler in RUN:
  - Increments each cycle.
  - When it equals prescale, a tick occurs and the prescaler returns to 0.
  - prescale=0 gives a tick every cycle.
- On a tick with cnt!=period: cnt<=cnt+1.
- On a tick with cnt==period (terminal event):
  - cout<=1 for exactly one cycle.
  - irq<=1.
  - overrun<=1 if irq was already 1 and irq_ack=0.
  - Periodic mode: cnt<=0 and stay in RUN.
  - One-shot mode: cnt holds at period and state goes to IDLE (busy falls at the same edge).
- Period formula: terminal events occur every (prescale+1)*(period+1) cycles. The first cout is high in the cycle following edge E0+(period+1)*(prescale+1), where E0 is the start-sampling edge.
- period=0: every tick is a terminal event; cnt stays 0.
- stop in RUN:
  - At the next edge, state goes to IDLE, cnt and prescaler hold, and no tick or terminal event is processed that cycle.
  - stop wins over a coincident terminal event and over a coincident start.
  - stop in IDLE has no effect.
- irq_ack: clears irq and overrun. If a terminal event and irq_ack coincide, the set wins (irq=1, overrun unchanged by that event).
- Restart after stop or one-shot completion always begins from cnt=0. Config is retained.
- Reset mid-RUN: immediate return to reset values, no cout.

Decomposition:
- Shared package cnt_timer_pkg holds:
  - state encoding (ST_IDLE, ST_RUN);
  - mode constants (MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1);
  - default config constants.
- One sub-module, cnt_prescaler:
  - Inputs: clk, rstn, clear, enable, prescale.
  - Output: tick.
  - Its tick gates the main counter.

Test Plan:
- Reset defaults: assert rstn=0 mid-run → cnt=0, busy=0, irq=0, cout=0 immediately. Release → period=15, prescale=0, mode=0.
- Periodic: cfg period=3, prescale=1, mode=1, then start → cnt steps every 2 cycles (0,1,2,3,0...). cout pulses 1 cycle, first at 8 cycles after the start edge, then every 8 cycles. irq=1 after the first pulse.
- One-shot: period=5, prescale=0, mode=0, start → cout once at cycle 6, busy falls at the same edge, cnt holds 5. A new start restarts from 0.
- Interrupt handshake: periodic period=1, prescale=0, never ack → overrun=1 after the second cout. irq_ack → irq=0, overrun=0. Ack coincident with cout → irq stays 1.
- Stop precedence: stop asserted in the exact cycle of a terminal event → no cout, irq unchanged, busy=0, cnt=period held. start+stop in IDLE → stays IDLE.
- Config guard: cfg_we during RUN with period=2 → cfg_err 1-cycle pulse, original period still in effect. period=0, prescale=0 → cout every cycle while RUN.
